// File: rtl/seq_detect_param.sv
// Serial pattern detector (Mealy) for a compile-time PATTERN of SEQ_LEN bits, with
// KMP mismatch fallback, runtime overlap mode, valid qualifier and saturating match count.
module seq_detect_param #(
    parameter int unsigned          SEQ_LEN = 4,
    parameter logic [SEQ_LEN-1:0]   PATTERN = 4'b1001,
    parameter int unsigned          CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x,
    input  logic             x_valid,
    input  logic             overlap,
    input  logic             clear_cnt,
    output logic             z,
    output logic             z_q,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int unsigned SW = $clog2(SEQ_LEN);
    localparam logic [SW-1:0] LAST = SW'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic pbit(input int unsigned i);
        logic [SEQ_LEN-1:0] t;
        t = PATTERN >> i;
        return t[0];
    endfunction

    // Longest prefix of PATTERN that is a suffix of (first s pattern bits, then b), capped
    // below SEQ_LEN; covers extension, mismatch fallback and the overlap border alike.
    function automatic logic [SW-1:0] kmp_next(input int unsigned s, input logic b);
        int unsigned best;
        int unsigned h;
        logic        ok;
        logic        hb;
        best = 0;
        for (int unsigned k = 1; k <= s + 1 && k < SEQ_LEN; k++) begin
            ok = 1'b1;
            for (int unsigned j = 0; j < k; j++) begin
                h  = s + 1 - k + j;
                hb = (h == s) ? b : pbit(SEQ_LEN - 1 - h);
                if (hb != pbit(SEQ_LEN - 1 - j)) ok = 1'b0;
            end
            if (ok) best = k;
        end
        return SW'(best);
    endfunction

    localparam logic [SW-1:0] BORDER = kmp_next(SEQ_LEN - 1, PATTERN[0]);

    logic [SW-1:0] nxt0 [SEQ_LEN];
    logic [SW-1:0] nxt1 [SEQ_LEN];

    for (genvar g = 0; g < SEQ_LEN; g++) begin : g_tbl
        assign nxt0[g] = kmp_next(g, 1'b0);
        assign nxt1[g] = kmp_next(g, 1'b1);
    end

    logic [SW-1:0]    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             zreg_q;
    logic             hit;

    always_comb begin
        hit     = x_valid && (state_q == LAST) && (x == PATTERN[0]);
        state_d = state_q;
        if (x_valid) begin
            if (hit) begin
                state_d = overlap ? BORDER : '0;
            end else begin
                state_d = x ? nxt1[state_q] : nxt0[state_q];
            end
        end
    end

    // Clear has priority over a coincident match.
    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clear_cnt) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (hit && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_MAX) sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            zreg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            zreg_q  <= hit;
        end
    end

    assign z         = hit;
    assign z_q       = zreg_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default instance plus a CNT_W=3 instance for saturation.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst_n, x, x_valid, overlap, clear_cnt;
    logic       z, z_q, cnt_sat;
    logic [7:0] match_cnt;
    logic       z3, z_q3, cnt_sat3;
    logic [2:0] match_cnt3;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    seq_detect_param dut (
        .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .overlap(overlap),
        .clear_cnt(clear_cnt), .z(z), .z_q(z_q), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    seq_detect_param #(.SEQ_LEN(4), .PATTERN(4'b1001), .CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .overlap(overlap),
        .clear_cnt(clear_cnt), .z(z3), .z_q(z_q3), .match_cnt(match_cnt3), .cnt_sat(cnt_sat3)
    );

    // Called one time unit after a rising edge; returns at the same phase one cycle later.
    task automatic step(input logic b, input logic v, output logic zo, output logic zqo);
        x = b;
        x_valid = v;
        #1 zo = z;
        @(posedge clk);
        #1 zqo = z_q;
    endtask

    task automatic pulse_reset();
        x_valid = 1'b0;
        clear_cnt = 1'b0;
        #3 rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; x = 1'b1; x_valid = 1'b1; overlap = 1'b0; clear_cnt = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL reset z: got %b want 0", z); end
        n_checks++; if (z_q !== 1'b0) begin n_fail++; $display("FAIL reset z_q: got %b want 0", z_q); end
        n_checks++; if (match_cnt !== 8'd0) begin n_fail++; $display("FAIL reset match_cnt: got %0d want 0", match_cnt); end
        n_checks++; if (cnt_sat !== 1'b0) begin n_fail++; $display("FAIL reset cnt_sat: got %b want 0", cnt_sat); end
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_overlap_mode(input logic ov, input logic [9:0] zexp, input int cnt_exp);
        logic [9:0] bits;
        logic zo, zqo;
        bits = 10'b1001001001;
        pulse_reset();
        overlap = ov;
        for (int i = 0; i < 10; i++) begin
            step(bits[9-i], 1'b1, zo, zqo);
            n_checks++;
            if (zo !== zexp[9-i]) begin
                n_fail++; $display("FAIL overlap=%b z bit %0d: got %b want %b", ov, i + 1, zo, zexp[9-i]);
            end
            n_checks++;
            if (zqo !== zexp[9-i]) begin
                n_fail++; $display("FAIL overlap=%b z_q after bit %0d: got %b want %b", ov, i + 1, zqo, zexp[9-i]);
            end
        end
        n_checks++;
        if (match_cnt !== 8'(cnt_exp)) begin
            n_fail++; $display("FAIL overlap=%b match_cnt: got %0d want %0d", ov, match_cnt, cnt_exp);
        end
    endtask

    task automatic test_fallback();
        logic [4:0] s1;
        logic [5:0] s2;
        logic zo, zqo;
        s1 = 5'b11001;
        s2 = 6'b101001;
        pulse_reset();
        overlap = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(s1[4-i], 1'b1, zo, zqo);
            n_checks++;
            if (zo !== (i == 4)) begin
                n_fail++; $display("FAIL fallback 11001 z bit %0d: got %b want %b", i + 1, zo, i == 4);
            end
        end
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            step(s2[5-i], 1'b1, zo, zqo);
            n_checks++;
            if (zo !== (i == 5)) begin
                n_fail++; $display("FAIL fallback 101001 z bit %0d: got %b want %b", i + 1, zo, i == 5);
            end
        end
    endtask

    task automatic test_qualifier();
        logic [6:0] bits, vld;
        logic zo, zqo;
        bits = 7'b1011101;
        vld  = 7'b1100011;
        pulse_reset();
        overlap = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(bits[6-i], vld[6-i], zo, zqo);
            n_checks++;
            if (zo !== (i == 6)) begin
                n_fail++; $display("FAIL qualifier z step %0d: got %b want %b", i + 1, zo, i == 6);
            end
        end
        n_checks++;
        if (match_cnt !== 8'd1) begin
            n_fail++; $display("FAIL qualifier match_cnt: got %0d want 1", match_cnt);
        end
    endtask

    task automatic test_counter();
        logic zo, zqo;
        pulse_reset();
        overlap = 1'b1;
        step(1'b1, 1'b1, zo, zqo);
        for (int k = 1; k <= 9; k++) begin
            step(1'b0, 1'b1, zo, zqo);
            step(1'b0, 1'b1, zo, zqo);
            x = 1'b1; x_valid = 1'b1;
            #1;
            n_checks++;
            if (z3 !== 1'b1) begin n_fail++; $display("FAIL counter z3 match %0d: got %b want 1", k, z3); end
            @(posedge clk);
            #1;
            n_checks++;
            if (match_cnt3 !== 3'((k < 7) ? k : 7)) begin
                n_fail++; $display("FAIL counter match_cnt3 match %0d: got %0d want %0d", k, match_cnt3, (k < 7) ? k : 7);
            end
            n_checks++;
            if (cnt_sat3 !== (k >= 7)) begin
                n_fail++; $display("FAIL counter cnt_sat3 match %0d: got %b want %b", k, cnt_sat3, k >= 7);
            end
            n_checks++;
            if (match_cnt !== 8'(k)) begin
                n_fail++; $display("FAIL counter match_cnt match %0d: got %0d want %0d", k, match_cnt, k);
            end
        end
        step(1'b0, 1'b1, zo, zqo);
        step(1'b0, 1'b1, zo, zqo);
        clear_cnt = 1'b1;
        step(1'b1, 1'b1, zo, zqo);
        clear_cnt = 1'b0;
        n_checks++; if (zo !== 1'b1) begin n_fail++; $display("FAIL clear+match z: got %b want 1", zo); end
        n_checks++; if (zqo !== 1'b1) begin n_fail++; $display("FAIL clear+match z_q: got %b want 1", zqo); end
        n_checks++; if (match_cnt3 !== 3'd0) begin n_fail++; $display("FAIL clear+match match_cnt3: got %0d want 0", match_cnt3); end
        n_checks++; if (cnt_sat3 !== 1'b0) begin n_fail++; $display("FAIL clear+match cnt_sat3: got %b want 0", cnt_sat3); end
        n_checks++; if (match_cnt !== 8'd0) begin n_fail++; $display("FAIL clear+match match_cnt: got %0d want 0", match_cnt); end
        step(1'b0, 1'b1, zo, zqo);
        step(1'b0, 1'b1, zo, zqo);
        step(1'b1, 1'b1, zo, zqo);
        n_checks++; if (match_cnt3 !== 3'd1) begin n_fail++; $display("FAIL post-clear match_cnt3: got %0d want 1", match_cnt3); end
        n_checks++; if (cnt_sat3 !== 1'b0) begin n_fail++; $display("FAIL post-clear cnt_sat3: got %b want 0", cnt_sat3); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] bits;
        logic zo, zqo;
        bits = 4'b1001;
        pulse_reset();
        overlap = 1'b0;
        for (int i = 0; i < 4; i++) step(bits[3-i], 1'b1, zo, zqo);
        n_checks++; if (zqo !== 1'b1) begin n_fail++; $display("FAIL mid-reset pre z_q: got %b want 1", zqo); end
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (z_q !== 1'b0) begin n_fail++; $display("FAIL mid-reset async z_q: got %b want 0", z_q); end
        n_checks++; if (match_cnt !== 8'd0) begin n_fail++; $display("FAIL mid-reset match_cnt: got %0d want 0", match_cnt); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(bits[3-i], 1'b1, zo, zqo);
        x = 1'b1; x_valid = 1'b1;
        #1;
        n_checks++; if (z !== 1'b1) begin n_fail++; $display("FAIL mid-reset pre z: got %b want 1", z); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL mid-reset async z: got %b want 0", z); end
        n_checks++; if (z_q !== 1'b0) begin n_fail++; $display("FAIL mid-reset z_q: got %b want 0", z_q); end
        x_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            step(bits[3-i], 1'b1, zo, zqo);
            n_checks++;
            if (zo !== (i == 3)) begin
                n_fail++; $display("FAIL after-reset z bit %0d: got %b want %b", i + 1, zo, i == 3);
            end
        end
        n_checks++; if (match_cnt !== 8'd1) begin n_fail++; $display("FAIL after-reset match_cnt: got %0d want 1", match_cnt); end
    endtask

    initial begin
        test_reset();
        test_overlap_mode(1'b0, 10'b0001000001, 2);
        test_overlap_mode(1'b1, 10'b0001001001, 3);
        test_fallback();
        test_qualifier();
        test_counter();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
